// File: rtl/debug_trace_uart.sv
// debug_trace_uart
//   Captures the core's per-instruction debug bus into a small record FIFO and
//   streams every record out over an 8N1 UART so a host can trace execution.
//   Each 104-bit record {pc, inst, wb, flags} becomes a 14-byte frame:
//   SYNC_BYTE, then pc, inst and wb most significant byte first, then flags.
//
// Ports
//   clk             system clock, all state on the rising edge
//   reset           asynchronous, active-low reset
//   i_capture_en    sample the debug bus on this edge
//   i_pcOut         core PC (32)
//   i_inst          core instruction (32)
//   i_writeBack     core writeback data (32)
//   i_RegWEn        register write enable
//   i_memRW         data memory write enable
//   i_BrEq          branch-equal flag
//   i_BrLT          branch-less-than flag
//   o_tx            UART serial out, idle high, registered
//   o_busy          high whenever the transmitter is not IDLE
//   o_fifo_count    records held in the FIFO
//   o_overflow_cnt  dropped records, saturating at 255
//   o_dbgState      current transmitter state (IDLE/START/DATA/STOP)
//
// Handshake: capture has no backpressure. A record offered with i_capture_en
// is either accepted that same edge or dropped and counted in o_overflow_cnt.
module debug_trace_uart #(
  parameter int          DEPTH        = 8,
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_capture_en,
  input  logic [31:0]              i_pcOut,
  input  logic [31:0]              i_inst,
  input  logic [31:0]              i_writeBack,
  input  logic                     i_RegWEn,
  input  logic                     i_memRW,
  input  logic                     i_BrEq,
  input  logic                     i_BrLT,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic [7:0]               o_overflow_cnt,
  output logic [1:0]               o_dbgState
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int RW = 104;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT          state, stateNext;
  logic [BW-1:0]  baudCnt, baudNext;
  logic [2:0]     bitCnt, bitNext;
  logic [3:0]     byteIdx, byteNext;
  logic           txReg, txNext;
  logic           pop, push, drop;

  logic [RW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wrPtr, rdPtr;
  logic [CW-1:0]  count;
  logic [RW-1:0]  hold;
  logic [7:0]     ovfCnt;
  logic [RW-1:0]  record;
  logic [7:0]     curByte;

  assign record = {i_pcOut, i_inst, i_writeBack, 4'b0000, i_RegWEn, i_memRW, i_BrEq, i_BrLT};

  // Byte 0 of the frame is the sync byte; bytes 1..13 walk the held record
  // from its most significant byte down.
  always_comb begin
    curByte = SYNC_BYTE;
    for (int k = 1; k < 14; k++) begin
      if (byteIdx == 4'(k)) curByte = hold[RW-8*k +: 8];
    end
  end

  always_comb begin
    stateNext = state;
    baudNext  = baudCnt + BW'(1);
    bitNext   = bitCnt;
    byteNext  = byteIdx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baudNext = '0;
        if (count != '0) begin
          pop       = 1'b1;
          byteNext  = '0;
          stateNext = START;
        end
      end
      START: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA;
        end
      end
      DATA: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = '0;
          if (bitCnt == 3'd7) stateNext = STOP;
          else                bitNext   = bitCnt + 3'd1;
        end
      end
      STOP: begin
        if (baudCnt == BAUD_LAST) begin
          baudNext = '0;
          if (byteIdx != 4'd13) begin
            byteNext  = byteIdx + 4'd1;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    // The line value is registered together with the state, so it is computed
    // for the state being entered. The held record is already valid by the
    // time DATA is entered, so byteIdx selects the right byte.
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = curByte[bitNext];
      default: txNext = 1'b1;
    endcase

    // A full FIFO still accepts when the head leaves on the same edge.
    push = i_capture_en && ((count != FULL) || pop);
    drop = i_capture_en && !push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitCnt  <= '0;
      byteIdx <= '0;
      txReg   <= 1'b1;
      hold    <= '0;
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      ovfCnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state   <= stateNext;
      baudCnt <= baudNext;
      bitCnt  <= bitNext;
      byteIdx <= byteNext;
      txReg   <= txNext;
      if (push) begin
        mem[wrPtr] <= record;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop) begin
        hold  <= mem[rdPtr];
        rdPtr <= rdPtr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop && (ovfCnt != 8'hFF)) ovfCnt <= ovfCnt + 8'd1;
    end
  end

  assign o_tx           = txReg;
  assign o_busy         = (state != IDLE);
  assign o_fifo_count   = count;
  assign o_overflow_cnt = ovfCnt;
  assign o_dbgState     = state;

endmodule
